// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared moduli, field widths and time record for the stopwatch blocks.
package stopwatch_pkg;
  localparam int TICK_HZ  = 100;
  localparam int MSEC_MAX = 100;
  localparam int SEC_MAX  = 60;
  localparam int MIN_MAX  = 60;
  localparam int HOUR_MAX = 24;
  localparam int MSEC_W   = 7;
  localparam int SEC_W    = 6;
  localparam int MIN_W    = 6;
  localparam int HOUR_W   = 5;
  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
    logic [SEC_W-1:0]  sec;
    logic [MSEC_W-1:0] msec;
  } time_t;
endpackage

// File: rtl/stopwatch_tick_gen.sv
// stopwatch_tick_gen: run/clear-gated clock divider producing the centisecond advance strobe.
module stopwatch_tick_gen #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int TICK_HZ     = stopwatch_pkg::TICK_HZ
)(
  input  logic clk,
  input  logic rst,
  input  logic i_run,
  input  logic i_clear,
  output logic o_adv,
  output logic o_tick
);
  localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int DW  = $clog2(DIV);
  if (DIV < 2 || DIV * TICK_HZ != CLK_FREQ_HZ) begin : g_bad_div
    $error("stopwatch_tick_gen: CLK_FREQ_HZ/TICK_HZ must be an integer >= 2");
  end
  logic [DW-1:0] r_div;
  // o_adv is the edge on which the counters step; o_tick is its registered echo
  assign o_adv = i_run && !i_clear && r_div == DW'(DIV - 1);
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_div  <= '0;
      o_tick <= 1'b0;
    end else begin
      o_tick <= o_adv;
      r_div  <= o_adv ? '0 : i_run ? r_div + 1'b1 : r_div;
    end
  end
endmodule

// File: rtl/stopwatch_dp.sv
// stopwatch_dp: 100 Hz divider feeding a single-edge cascade of msec/sec/min/hour counters.
module stopwatch_dp #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int TICK_HZ     = stopwatch_pkg::TICK_HZ,
  parameter int MSEC_MAX    = stopwatch_pkg::MSEC_MAX,
  parameter int SEC_MAX     = stopwatch_pkg::SEC_MAX,
  parameter int MIN_MAX     = stopwatch_pkg::MIN_MAX,
  parameter int HOUR_MAX    = stopwatch_pkg::HOUR_MAX
)(
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_runstop,
  input  logic                            i_clear,
  output logic [stopwatch_pkg::MSEC_W-1:0] o_msec,
  output logic [stopwatch_pkg::SEC_W-1:0]  o_sec,
  output logic [stopwatch_pkg::MIN_W-1:0]  o_min,
  output logic [stopwatch_pkg::HOUR_W-1:0] o_hour,
  output logic                            o_tick
);
  import stopwatch_pkg::*;
  if (MSEC_MAX > 2**MSEC_W || SEC_MAX > 2**SEC_W || MIN_MAX > 2**MIN_W || HOUR_MAX > 2**HOUR_W) begin : g_bad_mod
    $error("stopwatch_dp: modulus exceeds field width");
  end
  logic  w_adv;
  logic  w_ms_wrap;
  logic  w_s_wrap;
  logic  w_m_wrap;
  logic  w_h_wrap;
  time_t r_t;
  stopwatch_tick_gen #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ),
    .TICK_HZ    (TICK_HZ)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .i_run  (i_runstop),
    .i_clear(i_clear),
    .o_adv  (w_adv),
    .o_tick (o_tick)
  );
  assign w_ms_wrap = r_t.msec == MSEC_W'(MSEC_MAX - 1);
  assign w_s_wrap  = r_t.sec  == SEC_W'(SEC_MAX - 1);
  assign w_m_wrap  = r_t.min  == MIN_W'(MIN_MAX - 1);
  assign w_h_wrap  = r_t.hour == HOUR_W'(HOUR_MAX - 1);
  // carries decode the current values, so a full rollover lands on one edge
  always_ff @(posedge clk) begin
    if (rst || i_clear) r_t <= '0;
    else if (w_adv) begin
      r_t.msec <= w_ms_wrap ? '0 : r_t.msec + 1'b1;
      if (w_ms_wrap) r_t.sec <= w_s_wrap ? '0 : r_t.sec + 1'b1;
      if (w_ms_wrap && w_s_wrap) r_t.min <= w_m_wrap ? '0 : r_t.min + 1'b1;
      if (w_ms_wrap && w_s_wrap && w_m_wrap) r_t.hour <= w_h_wrap ? '0 : r_t.hour + 1'b1;
    end
  end
  assign o_msec = r_t.msec;
  assign o_sec  = r_t.sec;
  assign o_min  = r_t.min;
  assign o_hour = r_t.hour;
endmodule

// File: tb/tb_stopwatch_dp.sv
// tb_stopwatch_dp: directed scenarios with a queue-based scoreboard; u0 DIV=10, u1 DIV=2, u2 DIV=2 with small moduli.
module tb_stopwatch_dp;
  typedef struct {
    string       name;
    int          d;
    logic [23:0] t;
    logic        tick;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst [3];
  logic       run [3];
  logic       clr [3];
  logic [6:0] msec [3];
  logic [5:0] sec [3];
  logic [5:0] min [3];
  logic [4:0] hour [3];
  logic       tick [3];
  exp_t       q[$];
  exp_t       e;
  logic [23:0] act;
  int         checks = 0;
  int         errors = 0;
  always #5 clk = ~clk;
  stopwatch_dp #(.CLK_FREQ_HZ(1000), .TICK_HZ(100)) u0 (
    .clk(clk), .rst(rst[0]), .i_runstop(run[0]), .i_clear(clr[0]),
    .o_msec(msec[0]), .o_sec(sec[0]), .o_min(min[0]), .o_hour(hour[0]), .o_tick(tick[0]));
  stopwatch_dp #(.CLK_FREQ_HZ(200), .TICK_HZ(100)) u1 (
    .clk(clk), .rst(rst[1]), .i_runstop(run[1]), .i_clear(clr[1]),
    .o_msec(msec[1]), .o_sec(sec[1]), .o_min(min[1]), .o_hour(hour[1]), .o_tick(tick[1]));
  stopwatch_dp #(.CLK_FREQ_HZ(200), .TICK_HZ(100), .MSEC_MAX(4), .SEC_MAX(3), .MIN_MAX(3), .HOUR_MAX(2)) u2 (
    .clk(clk), .rst(rst[2]), .i_runstop(run[2]), .i_clear(clr[2]),
    .o_msec(msec[2]), .o_sec(sec[2]), .o_min(min[2]), .o_hour(hour[2]), .o_tick(tick[2]));
  always @(negedge clk) begin
    while (q.size() > 0) begin
      e = q.pop_front();
      act = {hour[e.d], min[e.d], sec[e.d], msec[e.d]};
      checks++;
      if (act !== e.t || tick[e.d] !== e.tick) begin
        errors++;
        $display("FAIL %s u%0d: got %0d:%0d:%0d.%0d tick=%b, expected %0d:%0d:%0d.%0d tick=%b",
                 e.name, e.d, act[23:19], act[18:13], act[12:7], act[6:0], tick[e.d],
                 e.t[23:19], e.t[18:13], e.t[12:7], e.t[6:0], e.tick);
      end
    end
  end
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic expect_t(input string n, input int d, input int h, input int m, input int s, input int ms, input logic tk);
    q.push_back('{n, d, {5'(h), 6'(m), 6'(s), 7'(ms)}, tk});
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1;
      run[i] = 1'b0;
      clr[i] = 1'b0;
    end
    step(2);
    expect_t("reset", 0, 0, 0, 0, 0, 0);
    rst[0] = 1'b0;
    run[0] = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      step();
      expect_t("run100", 0, 0, 0, 0, k / 10, k % 10 == 0);
    end
    clr[0] = 1'b1;
    step();
    expect_t("clear_pre_t2", 0, 0, 0, 0, 0, 0);
    clr[0] = 1'b0;
    step(45);
    expect_t("run45", 0, 0, 0, 0, 4, 0);
    run[0] = 1'b0;
    step(25);
    expect_t("stop_mid", 0, 0, 0, 0, 4, 0);
    step(25);
    expect_t("stop50", 0, 0, 0, 0, 4, 0);
    run[0] = 1'b1;
    step(4);
    expect_t("resume4", 0, 0, 0, 0, 4, 0);
    step();
    expect_t("resume5", 0, 0, 0, 0, 5, 1);
    step(320);
    expect_t("at37", 0, 0, 0, 0, 37, 1);
    step(9);
    expect_t("at37_div9", 0, 0, 0, 0, 37, 0);
    clr[0] = 1'b1;
    step();
    expect_t("clear_on_tick_edge", 0, 0, 0, 0, 0, 0);
    clr[0] = 1'b0;
    step(9);
    expect_t("after_clear9", 0, 0, 0, 0, 0, 0);
    step();
    expect_t("after_clear10", 0, 0, 0, 0, 1, 1);
    step(9);
    run[0] = 1'b0;
    step();
    expect_t("stop_on_tick_edge", 0, 0, 0, 0, 1, 0);
    run[0] = 1'b1;
    step();
    expect_t("resume_tick", 0, 0, 0, 0, 2, 1);
    clr[0] = 1'b1;
    for (int k = 0; k < 30; k++) begin
      step();
      expect_t("clear_and_run", 0, 0, 0, 0, 0, 0);
    end
    clr[0] = 1'b0;
    step(10);
    expect_t("post_hold_tick", 0, 0, 0, 0, 1, 1);
    rst[1] = 1'b0;
    run[1] = 1'b1;
    step(11998);
    expect_t("at_59_99", 1, 0, 0, 59, 99, 1);
    step();
    expect_t("at_59_99_hold", 1, 0, 0, 59, 99, 0);
    step();
    expect_t("to_1_00", 1, 0, 1, 0, 0, 1);
    step(14710);
    expect_t("at_2_13_55", 1, 0, 2, 13, 55, 1);
    rst[1] = 1'b1;
    #2 rst[1] = 1'b0;
    step();
    expect_t("rst_glitch", 1, 0, 2, 13, 55, 0);
    rst[1] = 1'b1;
    step();
    expect_t("rst_sync", 1, 0, 0, 0, 0, 0);
    rst[2] = 1'b0;
    run[2] = 1'b1;
    step(22);
    expect_t("day_sec_max", 2, 0, 0, 2, 3, 1);
    step(2);
    expect_t("day_min_carry", 2, 0, 1, 0, 0, 1);
    step(118);
    expect_t("day_max", 2, 1, 2, 2, 3, 1);
    step();
    expect_t("day_max_hold", 2, 1, 2, 2, 3, 0);
    step();
    expect_t("day_rollover", 2, 0, 0, 0, 0, 1);
    step(2);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/stopwatch_dp.md
Name: stopwatch_dp

Overview:
Stopwatch datapath that sits directly downstream of the stopwatch control unit. It consumes the control unit's level outputs: run (o_runstop → i_runstop) and clear (o_clear → i_clear). It produces a centisecond/second/minute/hour count for the FND/display and UART reporting stages. It contains a 100 Hz tick divider plus a cascaded chain of four wrap-around counters.

Parameters:
CLK_FREQ_HZ, 100_000_000, system clock frequency
TICK_HZ, 100, centisecond tick rate; DIV = CLK_FREQ_HZ / TICK_HZ, must be an integer ≥ 2
MSEC_MAX, 100, centisecond modulus
SEC_MAX, 60, second modulus
MIN_MAX, 60, minute modulus
HOUR_MAX, 24, hour modulus

Ports:
clk  input  1  system clock; all state on rising edge
rst  input  1  synchronous, active-high reset
i_runstop  input  1  level; 1 = count, 0 = hold
i_clear  input  1  level; 1 = hold all state at zero
o_msec  output  7  centiseconds, 0..99
o_sec  output  6  seconds, 0..59
o_min  output  6  minutes, 0..59
o_hour  output  5  hours, 0..23
o_tick  output  1  one-cycle pulse on the cycle the centisecond counter advances

Behaviour:
- One clock domain. Reset is synchronous and active-high: on a clk edge with rst=1, divider=0, all counters=0, o_tick=0.
- All outputs are registered. Reset value of every output is 0.
- Priority per edge: rst > i_clear > i_runstop.
- Clear: while i_clear=1, divider and all four counters load 0 and o_tick=0 every cycle, regardless of i_runstop. Clear is level-held, not a pulse.
- Run (i_runstop=1, i_clear=0): the divider counts 0..DIV-1.
  - On the edge where divider==DIV-1, the divider wraps to 0 and the tick fires.
  - Counters and o_tick update on that same edge, so o_tick is high for exactly the cycle in which the new o_msec is visible.
- Stop (i_runstop=0, i_clear=0): divider and counters hold their values and o_tick=0.
  - The partial divider count is preserved, so resuming does not lose or gain a fraction of a tick.
- Cascade on tick:
  - msec increments. At MSEC_MAX-1 it wraps to 0 and carries into sec.
  - sec wraps at SEC_MAX-1 and carries into min.
  - min wraps at MIN_MAX-1 and carries into hour.
  - hour wraps at HOUR_MAX-1 to 0. Full rollover is 23:59:59.99 → 00:00:00.00 on a single edge.
  - All carries are combinational from the current values within one edge, so there is no ripple latency between digits.
- Counts never exceed modulus-1. Any out-of-range value is unreachable and needs no handling.
- Run→stop in the same cycle as a tick boundary: i_runstop is sampled at the edge. If it is 0 at that edge, no tick occurs.
- Clear asserted mid-run: all fields read 0 on the following cycle, and no tick fires on the clearing edge.
- Clear→run transition: the first tick occurs DIV cycles after the first edge with i_clear=0 and i_runstop=1.

Decomposition:
- Shared package stopwatch_pkg holds:
  - modulus constants MSEC_MAX, SEC_MAX, MIN_MAX, HOUR_MAX;
  - field widths MSEC_W=7, SEC_W=6, MIN_W=6, HOUR_W=5;
  - the default TICK_HZ, reused by the watch datapath and the display formatter.
- One natural sub-module: stopwatch_tick_gen (divider with run/clear inputs, tick output).
- The four counters are instances of a generic modulo counter with carry-in/carry-out, or inline logic; either is acceptable.

Test Plan:
All scenarios use CLK_FREQ_HZ=1000, TICK_HZ=100, giving DIV=10.
1. Reset, then run=1 for 100 cycles → o_msec=10, and o_tick has pulsed exactly 10 times, each 1 cycle wide, 10 cycles apart.
2. Run for 45 cycles, stop for 50 cycles, run for 5 more cycles → o_msec goes 4 → 4 (holds) → 5. The fractional divider count is preserved.
3. Preload by running to 00:00:59.99, then one more tick → output 00:01:00.00 on a single edge. Continue to 23:59:59.99, then one tick → 00:00:00.00.
4. During run at msec=37, assert i_clear for 1 cycle → next cycle all outputs are 0. With run held, the first new tick comes 10 cycles after clear deasserts.
5. Drive i_clear=1 and i_runstop=1 together for 30 cycles → outputs stay 0 and o_tick never asserts.
6. Assert rst mid-count at 00:02:13.55 → outputs are 0 on the next edge (synchronous reset). Asserting rst between clock edges has no effect until the next edge.
